// File: rtl/tt_um_asiclab_nibble_div.sv
// Sequential 4-bit restoring divider tile: Q = N / D, R = N % D, one quotient bit per clock.
// Define ASICLAB_DIV_COUNT_EN to add a 4-bit completion counter on uio_out[7:4].
module tt_um_asiclab_nibble_div (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t     state, state_next;
    logic [3:0] n_reg, d_reg, q_reg;
    logic [4:0] p_reg;
    logic [1:0] count;
    logic [7:0] result;
    logic       dz;
    logic       start, launch, finish, busy, done;
    logic [1:0] bit_idx;
    logic [4:0] p_shift, p_next;
    logic [3:0] q_next;
    logic       unused_ok;

    assign start     = uio_in[0];
    assign unused_ok = &{1'b0, ena, uio_in[7:1]};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (start) begin
                launch     = 1'b1;
                state_next = RUN;
            end
            RUN: if (count == 2'd3) begin
                finish     = 1'b1;
                state_next = DONE;
            end
            DONE: if (start) begin
                launch     = 1'b1;
                state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend bit (MSB first), subtract D when it fits.
    always_comb begin
        bit_idx = 2'd3 - count;
        p_shift = {p_reg[3:0], n_reg[bit_idx]};
        p_next  = p_shift;
        q_next  = q_reg;
        if (p_shift >= {1'b0, d_reg}) begin
            p_next  = p_shift - {1'b0, d_reg};
            q_next  = q_reg | (4'b0001 << bit_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_reg  <= '0;
            d_reg  <= '0;
            p_reg  <= '0;
            q_reg  <= '0;
            count  <= '0;
            result <= '0;
            dz     <= 1'b0;
        end else if (launch) begin
            n_reg <= ui_in[7:4];
            d_reg <= ui_in[3:0];
            p_reg <= '0;
            q_reg <= '0;
            count <= '0;
            dz    <= 1'b0;
        end else if (state == RUN) begin
            p_reg <= p_next;
            q_reg <= q_next;
            count <= count + 2'd1;
            if (finish) begin
                result <= {p_next[3:0], q_next};
                dz     <= (d_reg == 4'd0);
            end
        end
    end

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign uo_out = result;
    assign uio_oe = 8'hFE;

`ifdef ASICLAB_DIV_COUNT_EN
    logic [3:0] done_count;

    always_ff @(posedge clk) begin
        if (reset)       done_count <= '0;
        else if (finish) done_count <= done_count + 4'd1;
    end

    assign uio_out = {done_count, dz, done, busy, 1'b0};
`else
    assign uio_out = {4'b0000, dz, done, busy, 1'b0};
`endif

endmodule
